traffic_light_ctrl: RTL and testbench



---
 rtl/tlc_pkg.sv | 34 +++
 rtl/tlc_delay_timer.sv | 18 +
 rtl/traffic_light_ctrl.sv | 73 +++++++
 tb/tb_traffic_light_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared lamp codes, state encodings and lamp decode helpers for the traffic light controller.
package tlc_pkg;
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam logic [2:0] S0 = 3'd0;  // highway green
  localparam logic [2:0] S1 = 3'd1;  // highway yellow
  localparam logic [2:0] S2 = 3'd2;  // all red
  localparam logic [2:0] S3 = 3'd3;  // country green
  localparam logic [2:0] S4 = 3'd4;  // country yellow

  function automatic logic [1:0] hwy_lamp(input logic [2:0] s);
    case (s)
      S0:      hwy_lamp = GREEN;
      S1:      hwy_lamp = YELLOW;
      default: hwy_lamp = RED;
    endcase
  endfunction

  function automatic logic [1:0] cntry_lamp(input logic [2:0] s);
    case (s)
      S3:      cntry_lamp = GREEN;
      S4:      cntry_lamp = YELLOW;
      default: cntry_lamp = RED;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/tlc_delay_timer.sv
// Loadable up-counter: cleared on state entry, counts while enabled, flags count == limit-1.
module tlc_delay_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         done
);
  assign done = en && (count == limit - 1'b1);

  always_ff @(posedge clk) begin
    if (clr)     count <= '0;
    else if (en) count <= count + 1'b1;
  end
endmodule

// File: rtl/traffic_light_ctrl.sv
// Highway/country-road crossing controller (Moore FSM, registered lamp outputs).
// Define CNTRY_TIMEOUT_EN to cap country green at MAX_CNTRY_GRN cycles.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int Y2R_DELAY     = 3,
  parameter int R2G_DELAY     = 2,
  parameter int MAX_CNTRY_GRN = 32
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       X,
  output logic [1:0] hwy,
  output logic [1:0] cntry
);
  localparam int CW = $clog2(max3(Y2R_DELAY, R2G_DELAY, MAX_CNTRY_GRN) + 1);

  logic [2:0]    state, nxt;
  logic [CW-1:0] delay_counter, limit;
  logic          timed, done;

  always_comb begin
    timed = 1'b0;
    limit = '0;
    case (state)
      S1, S4: begin timed = 1'b1; limit = CW'(Y2R_DELAY); end
      S2:     begin timed = 1'b1; limit = CW'(R2G_DELAY); end
      S3: begin
`ifdef CNTRY_TIMEOUT_EN
        timed = 1'b1;
`else
        timed = 1'b0;
`endif
        limit = CW'(MAX_CNTRY_GRN);
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      S0:      if (X)           nxt = S1;
      S1:      if (done)        nxt = S2;
      S2:      if (done)        nxt = S3;
      S3:      if (!X || done)  nxt = S4;
      S4:      if (done)        nxt = S0;
      default:                  nxt = S0;
    endcase
  end

  // Any state change restarts the timer so every state is entered with a zero count.
  tlc_delay_timer #(.W(CW)) u_timer (
    .clk   (clock),
    .clr   (clear || (nxt != state)),
    .en    (timed),
    .limit (limit),
    .count (delay_counter),
    .done  (done)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S0;
      hwy   <= GREEN;
      cntry <= RED;
    end else begin
      state <= nxt;
      hwy   <= hwy_lamp(nxt);
      cntry <= cntry_lamp(nxt);
    end
  end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed phase checks plus random X against a phase/age model.
// Honours CNTRY_TIMEOUT_EN the same way as the design.
module tb_traffic_light_ctrl;
  localparam int Y2R  = 3;
  localparam int R2G  = 2;
  localparam int MAXG = 32;

  logic       clock, clear, X;
  logic [1:0] hwy, cntry;

  int total = 0;
  int bad   = 0;

  // model: current phase index and cycles spent in it
  int m_s   = 0;
  int m_age = 0;
  int hwy_of[5]   = '{2, 1, 0, 0, 0};
  int cntry_of[5] = '{0, 0, 0, 2, 1};

  traffic_light_ctrl #(.Y2R_DELAY(Y2R), .R2G_DELAY(R2G), .MAX_CNTRY_GRN(MAXG)) dut (
    .clock (clock),
    .clear (clear),
    .X     (X),
    .hwy   (hwy),
    .cntry (cntry)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int dur(input int s);
    case (s)
      1, 4: dur = Y2R;
      2:    dur = R2G;
`ifdef CNTRY_TIMEOUT_EN
      3:    dur = MAXG;
`endif
      default: dur = 0;
    endcase
  endfunction

  // Drive one cycle, advance the model on the same edge, then settle past the edge.
  task automatic step(input logic x, input logic clr);
    bit leave;
    X = x;
    clear = clr;
    @(posedge clock);
    if (clr) begin
      m_s = 0; m_age = 0;
    end else begin
      leave = (m_s == 0 && x) || (m_s == 3 && !x) ||
              (dur(m_s) != 0 && m_age + 1 == dur(m_s));
      if (leave) begin m_s = (m_s + 1) % 5; m_age = 0; end
      else m_age++;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    total++;
    if (dut.state !== 3'd0 || dut.delay_counter !== 0 || hwy !== 2'd2 || cntry !== 2'd0) begin
      bad++;
      $display("FAIL reset: state=%0d cnt=%0d hwy=%0d cntry=%0d want 0/0/2/0",
               dut.state, dut.delay_counter, hwy, cntry);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      total++;
      if (dut.state !== 3'd0 || dut.delay_counter !== 0 || hwy !== 2'd2 || cntry !== 2'd0) begin
        bad++;
        $display("FAIL idle_hold[%0d]: state=%0d cnt=%0d hwy=%0d cntry=%0d want 0/0/2/0",
                 i, dut.state, dut.delay_counter, hwy, cntry);
      end
    end
  endtask

  task automatic test_car_cycle();
    step(1'b1, 1'b0);
    total++;
    if (dut.state !== 3'd1 || hwy !== 2'd1 || cntry !== 2'd0) begin
      bad++;
      $display("FAIL car_arrive: state=%0d hwy=%0d cntry=%0d want 1/1/0", dut.state, hwy, cntry);
    end
    // X toggles during timed phases must be ignored
    for (int i = 0; i < Y2R; i++) step(1'($urandom_range(0, 1)), 1'b0);
    total++;
    if (dut.state !== 3'd2 || hwy !== 2'd0 || cntry !== 2'd0) begin
      bad++;
      $display("FAIL all_red: state=%0d hwy=%0d cntry=%0d want 2/0/0", dut.state, hwy, cntry);
    end
    for (int i = 0; i < R2G; i++) step(1'b1, 1'b0);
    total++;
    if (dut.state !== 3'd3 || hwy !== 2'd0 || cntry !== 2'd2) begin
      bad++;
      $display("FAIL cntry_green: state=%0d hwy=%0d cntry=%0d want 3/0/2", dut.state, hwy, cntry);
    end
    step(1'b0, 1'b0);
    total++;
    if (dut.state !== 3'd4 || hwy !== 2'd0 || cntry !== 2'd1) begin
      bad++;
      $display("FAIL car_leave: state=%0d hwy=%0d cntry=%0d want 4/0/1", dut.state, hwy, cntry);
    end
    for (int i = 0; i < Y2R; i++) step(1'b0, 1'b0);
    total++;
    if (dut.state !== 3'd0 || hwy !== 2'd2 || cntry !== 2'd0 || dut.delay_counter !== 0) begin
      bad++;
      $display("FAIL back_hwy: state=%0d hwy=%0d cntry=%0d cnt=%0d want 0/2/0/0",
               dut.state, hwy, cntry, dut.delay_counter);
    end
  endtask

  task automatic test_back_to_back();
    int exp_s[10] = '{4, 4, 4, 0, 1, 1, 1, 2, 2, 3};
    for (int i = 0; i < 1 + Y2R + R2G + 2; i++) step(1'b1, 1'b0);
    total++;
    if (dut.state !== 3'd3) begin
      bad++;
      $display("FAIL b2b_setup: state=%0d want 3", dut.state);
    end
    for (int i = 0; i < 10; i++) begin
      step(i != 0, 1'b0);
      total++;
      if (dut.state !== 3'(exp_s[i]) || hwy !== 2'(hwy_of[exp_s[i]]) || cntry !== 2'(cntry_of[exp_s[i]])) begin
        bad++;
        $display("FAIL b2b[%0d]: state=%0d hwy=%0d cntry=%0d want state %0d", i, dut.state, hwy, cntry, exp_s[i]);
      end
    end
    step(1'b0, 1'b0);
    for (int i = 0; i < Y2R; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0);
    for (int i = 0; i < Y2R + 1; i++) step(1'b0, 1'b0);
    total++;
    if (dut.state !== 3'd2 || dut.delay_counter !== 1) begin
      bad++;
      $display("FAIL mid_setup: state=%0d cnt=%0d want 2/1", dut.state, dut.delay_counter);
    end
    step(1'b0, 1'b1);
    total++;
    if (dut.state !== 3'd0 || dut.delay_counter !== 0 || hwy !== 2'd2 || cntry !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset: state=%0d cnt=%0d hwy=%0d cntry=%0d want 0/0/2/0",
               dut.state, dut.delay_counter, hwy, cntry);
    end
  endtask

  task automatic test_timeout();
    int seq[50];
    int run;
    bit reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step(1'b1, 1'b0);
      if (dut.state == 3'd3) reached = 1;
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL timeout_reach: state=%0d want 3 within 20 cycles", dut.state);
    end
    seq[0] = 3;
    for (int i = 1; i < 50; i++) begin
      step(1'b1, 1'b0);
      seq[i] = int'(dut.state);
    end
    run = 0;
    while (run < 50 && seq[run] == 3) run++;
`ifdef CNTRY_TIMEOUT_EN
    total++;
    if (run != MAXG) begin
      bad++;
      $display("FAIL timeout_len: S3 lasted %0d want %0d", run, MAXG);
    end
    total++;
    if (seq[MAXG] != 4 || seq[MAXG+2] != 4 || seq[MAXG+3] != 0 || seq[MAXG+4] != 1) begin
      bad++;
      $display("FAIL timeout_after: got %0d %0d %0d %0d want 4 4 0 1",
               seq[MAXG], seq[MAXG+2], seq[MAXG+3], seq[MAXG+4]);
    end
`else
    total++;
    if (run != 50) begin
      bad++;
      $display("FAIL no_timeout_len: S3 lasted %0d want 50", run);
    end
`endif
    step(1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic x, c;
    for (int i = 0; i < 400; i++) begin
      x = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 99) < 3);
      step(x, c);
      total++;
      if (dut.state !== 3'(m_s) || hwy !== 2'(hwy_of[m_s]) || cntry !== 2'(cntry_of[m_s]) ||
          dut.delay_counter !== ((dur(m_s) != 0) ? m_age : 0)) begin
        bad++;
        $display("FAIL random[%0d]: state=%0d cnt=%0d hwy=%0d cntry=%0d want %0d/%0d/%0d/%0d",
                 i, dut.state, dut.delay_counter, hwy, cntry, m_s,
                 (dur(m_s) != 0) ? m_age : 0, hwy_of[m_s], cntry_of[m_s]);
      end
      total++;
      if (hwy !== 2'd0 && cntry !== 2'd0) begin
        bad++;
        $display("FAIL conflict[%0d]: hwy=%0d cntry=%0d want one RED", i, hwy, cntry);
      end
    end
  endtask

  initial begin
    X = 1'b0;
    clear = 1'b1;
    test_reset();
    test_car_cycle();
    test_back_to_back();
    test_mid_reset();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
